// File: rtl/quant_block_scheduler.sv
// Round-robin 8x8 block scheduler sharing one quantization datapath between Y, Cb and Cr streams.
// Define QUANT_STATS_EN to add per-component block counters and a credit-stall counter.
module quant_block_scheduler #(
    parameter int MUL_LAT    = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        y_valid,
    input  logic [31:0] y_data,
    output logic        y_ready,
    input  logic        cb_valid,
    input  logic [31:0] cb_data,
    output logic        cb_ready,
    input  logic        cr_valid,
    input  logic [31:0] cr_data,
    output logic        cr_ready,
    output logic        mul_valid,
    output logic [31:0] mul_a,
    output logic        mul_tbl,
    output logic [2:0]  mul_row,
    output logic [2:0]  mul_col,
    input  logic        mul_res_valid,
    input  logic [31:0] mul_res,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [1:0]  out_comp,
    output logic        out_last,
    input  logic        out_ready
`ifdef QUANT_STATS_EN
    ,
    output logic [15:0] stat_blk_y,
    output logic [15:0] stat_blk_cb,
    output logic [15:0] stat_blk_cr,
    output logic [15:0] stat_stall
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LAT_W = $clog2(MUL_LAT + 1);

    typedef enum logic [0:0] {ARB, STREAM} state_t;
    typedef enum logic [1:0] {COMP_Y = 2'd0, COMP_CB = 2'd1, COMP_CR = 2'd2} comp_t;

    typedef struct packed {
        logic  valid;
        comp_t comp;
        logic  last;
    } tag_t;

    function automatic comp_t comp_next(input comp_t c);
        case (c)
            COMP_Y:  return COMP_CB;
            COMP_CB: return COMP_CR;
            default: return COMP_Y;
        endcase
    endfunction

    state_t            state;
    comp_t             rr_ptr;
    comp_t             grant;
    comp_t             arb_pick;
    comp_t             cand;
    logic              arb_any;
    logic [2:0]        req;
    logic [5:0]        k;

    logic              g_valid;
    logic [31:0]       g_data;
    logic              stream_active;
    logic              credit_ok;
    logic              handshake;

    tag_t              tag_pipe [MUL_LAT];
    logic [LAT_W-1:0]  inflight;

    logic [31:0]       fifo_data [FIFO_DEPTH];
    comp_t             fifo_comp [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              push;
    logic              pop;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping Y, Cb, Cr.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        req      = {cr_valid, cb_valid, y_valid};
        arb_any  = 1'b0;
        arb_pick = rr_ptr;
        cand     = rr_ptr;
        for (int i = 0; i < 3; i++) begin
            if (!arb_any && req[cand]) begin
                arb_any  = 1'b1;
                arb_pick = cand;
            end
            cand = comp_next(cand);
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_data  = y_data;
        case (grant)
            COMP_Y:  begin g_valid = y_valid;  g_data = y_data;  end
            COMP_CB: begin g_valid = cb_valid; g_data = cb_data; end
            COMP_CR: begin g_valid = cr_valid; g_data = cr_data; end
            default: begin g_valid = 1'b0;     g_data = y_data;  end
        endcase
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            inflight = inflight + LAT_W'(tag_pipe[i].valid);
        end
    end

    // Issue only when the FIFO is guaranteed a free slot for every outstanding result.
    assign credit_ok     = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
    assign stream_active = (state == STREAM);
    assign handshake     = stream_active && g_valid && credit_ok;

    assign y_ready  = stream_active && credit_ok && (grant == COMP_Y);
    assign cb_ready = stream_active && credit_ok && (grant == COMP_CB);
    assign cr_ready = stream_active && credit_ok && (grant == COMP_CR);

    assign mul_valid = handshake;
    assign mul_a     = g_data;
    assign mul_tbl   = (grant != COMP_Y);
    assign mul_row   = k[2:0];
    assign mul_col   = k[5:3];

    // NOTE: sequential state is updated with <= only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ARB;
            rr_ptr <= COMP_Y;
            grant  <= COMP_Y;
            k      <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (arb_any) begin
                        grant  <= arb_pick;
                        rr_ptr <= comp_next(arb_pick);
                        k      <= '0;
                        state  <= STREAM;
                    end
                end
                STREAM: begin
                    if (handshake) begin
                        k <= k + 6'd1;
                        if (k == 6'd63) begin
                            state <= ARB;
                        end
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // Component/last tags travel alongside the datapath so each result keeps its identity.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: handshake, comp: grant, last: (k == 6'd63)};
            for (int i = 1; i < MUL_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign out_valid = (fifo_count != '0);
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = mul_res_valid && tag_pipe[MUL_LAT-1].valid && (!fifo_full || pop);

    // NOTE: the FIFO storage is deliberately not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mul_res;
            fifo_comp[wr_ptr] <= tag_pipe[MUL_LAT-1].comp;
            fifo_last[wr_ptr] <= tag_pipe[MUL_LAT-1].last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    assign out_data = fifo_data[rd_ptr];
    assign out_comp = fifo_comp[rd_ptr];
    assign out_last = fifo_last[rd_ptr];

`ifdef QUANT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_blk_y  <= '0;
            stat_blk_cb <= '0;
            stat_blk_cr <= '0;
            stat_stall  <= '0;
        end else begin
            if (pop && out_last) begin
                case (fifo_comp[rd_ptr])
                    COMP_Y:  stat_blk_y  <= stat_blk_y + 16'd1;
                    COMP_CB: stat_blk_cb <= stat_blk_cb + 16'd1;
                    COMP_CR: stat_blk_cr <= stat_blk_cr + 16'd1;
                    default: ;
                endcase
            end
            if (stream_active && g_valid && !credit_ok) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_quant_block_scheduler.sv
// Directed testbench for quant_block_scheduler with a behavioural fixed-latency datapath model.
`timescale 1ns/1ps
module tb_quant_block_scheduler;

    localparam int MUL_LAT    = 3;
    localparam int FIFO_DEPTH = 8;
    localparam logic [31:0] Y_BASE  = 32'h1000_0000;
    localparam logic [31:0] CB_BASE = 32'h2000_0000;
    localparam logic [31:0] CR_BASE = 32'h3000_0000;
    localparam logic [31:0] SIGN    = 32'h8000_0000;

    logic        clk, rst;
    logic        y_valid, cb_valid, cr_valid;
    logic [31:0] y_data, cb_data, cr_data;
    logic        y_ready, cb_ready, cr_ready;
    logic        mul_valid, mul_tbl;
    logic [31:0] mul_a;
    logic [2:0]  mul_row, mul_col;
    logic        mul_res_valid;
    logic [31:0] mul_res;
    logic        out_valid, out_last, out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_comp;
`ifdef QUANT_STATS_EN
    logic [15:0] stat_blk_y, stat_blk_cb, stat_blk_cr, stat_stall;
`endif

    quant_block_scheduler #(.MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready),
        .cb_valid(cb_valid), .cb_data(cb_data), .cb_ready(cb_ready),
        .cr_valid(cr_valid), .cr_data(cr_data), .cr_ready(cr_ready),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_tbl(mul_tbl),
        .mul_row(mul_row), .mul_col(mul_col),
        .mul_res_valid(mul_res_valid), .mul_res(mul_res),
        .out_valid(out_valid), .out_data(out_data), .out_comp(out_comp),
        .out_last(out_last), .out_ready(out_ready)
`ifdef QUANT_STATS_EN
        , .stat_blk_y(stat_blk_y), .stat_blk_cb(stat_blk_cb),
        .stat_blk_cr(stat_blk_cr), .stat_stall(stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        tbl;
        logic [2:0]  row;
        logic [2:0]  col;
        int          cyc;
    } issue_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  comp;
        logic        last;
        int          cyc;
    } pop_t;

    issue_t      iss_q[$];
    pop_t        out_q[$];
    int          total, bad, cyc;
    int          y_total, cb_total, cr_total, y_sent, cb_sent, cr_sent;
    int          first_acc_cyc, multi_ready;
    bit          y_const;
    logic [31:0] y_const_val;
    logic        out_rdy, rst_drive;
    logic        pipe_v [MUL_LAT];
    logic [31:0] pipe_a [MUL_LAT];
    logic        last_v;
    logic [31:0] last_a;
    logic        s_y_ready, s_cb_ready, s_cr_ready, s_mul_valid, s_out_valid;

    // One clock cycle: drive at the falling edge, sample 1 ns later, capture at the next rising edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        rst = rst_drive;
        for (int i = MUL_LAT - 1; i > 0; i--) begin
            pipe_v[i] = pipe_v[i-1];
            pipe_a[i] = pipe_a[i-1];
        end
        pipe_v[0]     = last_v;
        pipe_a[0]     = last_a;
        mul_res_valid = pipe_v[MUL_LAT-1];
        mul_res       = pipe_a[MUL_LAT-1] ^ SIGN;
        y_valid  = (y_sent < y_total);
        y_data   = y_const ? y_const_val : Y_BASE + 32'(y_sent);
        cb_valid = (cb_sent < cb_total);
        cb_data  = CB_BASE + 32'(cb_sent);
        cr_valid = (cr_sent < cr_total);
        cr_data  = CR_BASE + 32'(cr_sent);
        out_ready = out_rdy;
        #1;
        s_y_ready   = y_ready;
        s_cb_ready  = cb_ready;
        s_cr_ready  = cr_ready;
        s_mul_valid = mul_valid;
        s_out_valid = out_valid;
        if (int'(y_ready) + int'(cb_ready) + int'(cr_ready) > 1) multi_ready++;
        last_v = mul_valid;
        last_a = mul_a;
        if (mul_valid) iss_q.push_back('{a: mul_a, tbl: mul_tbl, row: mul_row, col: mul_col, cyc: cyc});
        if (out_valid && out_ready) out_q.push_back('{data: out_data, comp: out_comp, last: out_last, cyc: cyc});
        if (y_valid && y_ready) begin
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            y_sent++;
        end
        if (cb_valid && cb_ready) cb_sent++;
        if (cr_valid && cr_ready) cr_sent++;
    endtask

    task automatic clear_streams();
        y_total = 0; cb_total = 0; cr_total = 0;
        y_sent = 0;  cb_sent = 0;  cr_sent = 0;
        y_const = 1'b0;
        first_acc_cyc = -1;
        multi_ready = 0;
        iss_q.delete();
        out_q.delete();
    endtask

    task automatic reset_dut();
        y_total = 0; cb_total = 0; cr_total = 0;
        rst_drive = 1'b1;
        last_v = 1'b0;
        for (int i = 0; i < MUL_LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = '0;
        end
        step();
        step();
        rst_drive = 1'b0;
        out_rdy = 1'b1;
        clear_streams();
    endtask

    task automatic wait_outputs(input int n, input int budget, input string name);
        int left;
        left = budget;
        while (out_q.size() < n && left > 0) begin
            step();
            left--;
        end
        total++;
        if (out_q.size() < n) begin
            bad++;
            $display("FAIL %s_timeout got=%0d outputs want=%0d", name, out_q.size(), n);
        end
    endtask

    function automatic logic [31:0] rr_exp_a(input int i);
        int b, j;
        b = i / 64;
        j = i % 64;
        case (b)
            0:       return Y_BASE + 32'(j);
            1:       return CB_BASE + 32'(j);
            2:       return CR_BASE + 32'(j);
            default: return Y_BASE + 32'(64 + j);
        endcase
    endfunction

    function automatic logic [1:0] rr_exp_comp(input int i);
        return (i / 64 == 3) ? 2'd0 : 2'(i / 64);
    endfunction

    task automatic test_reset();
        rst_drive = 1'b1;
        y_total = 64; cb_total = 64; cr_total = 64;
        step(); step(); step();
        total += 5;
        if (s_y_ready !== 1'b0)   begin bad++; $display("FAIL rst_y_ready got=%b want=0", s_y_ready); end
        if (s_cb_ready !== 1'b0)  begin bad++; $display("FAIL rst_cb_ready got=%b want=0", s_cb_ready); end
        if (s_cr_ready !== 1'b0)  begin bad++; $display("FAIL rst_cr_ready got=%b want=0", s_cr_ready); end
        if (s_mul_valid !== 1'b0) begin bad++; $display("FAIL rst_mul_valid got=%b want=0", s_mul_valid); end
        if (s_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", s_out_valid); end
        clear_streams();
        rst_drive = 1'b0;
        out_rdy = 1'b1;
        step(); step(); step();
        total += 2;
        if ({s_y_ready, s_cb_ready, s_cr_ready} !== 3'b000) begin
            bad++; $display("FAIL idle_readys got=%b want=000", {s_y_ready, s_cb_ready, s_cr_ready});
        end
        if (s_out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b want=0", s_out_valid); end
    endtask

    task automatic test_y_block();
        reset_dut();
        y_const = 1'b1;
        y_const_val = 32'h4280_0000;
        y_total = 64;
        wait_outputs(64, 300, "y_block");
        repeat (10) step();
        total++;
        if (iss_q.size() != 64) begin bad++; $display("FAIL y_issue_count got=%0d want=64", iss_q.size()); end
        for (int i = 0; i < iss_q.size() && i < 64; i++) begin
            total++;
            if (iss_q[i].tbl !== 1'b0 || iss_q[i].row !== 3'(i % 8) || iss_q[i].col !== 3'(i / 8)
                || iss_q[i].a !== 32'h4280_0000) begin
                bad++;
                $display("FAIL y_issue[%0d] got a=%h tbl=%b row=%0d col=%0d want a=42800000 tbl=0 row=%0d col=%0d",
                         i, iss_q[i].a, iss_q[i].tbl, iss_q[i].row, iss_q[i].col, i % 8, i / 8);
            end
        end
        total++;
        if (out_q.size() != 64) begin bad++; $display("FAIL y_out_count got=%0d want=64", out_q.size()); end
        for (int i = 0; i < out_q.size() && i < 64; i++) begin
            total++;
            if (out_q[i].data !== 32'hC280_0000 || out_q[i].comp !== 2'd0 || out_q[i].last !== (i == 63)) begin
                bad++;
                $display("FAIL y_out[%0d] got data=%h comp=%0d last=%b want data=c2800000 comp=0 last=%b",
                         i, out_q[i].data, out_q[i].comp, out_q[i].last, i == 63);
            end
        end
        if (out_q.size() > 0) begin
            total++;
            if (out_q[0].cyc - first_acc_cyc != MUL_LAT + 1) begin
                bad++;
                $display("FAIL y_latency got=%0d want=%0d", out_q[0].cyc - first_acc_cyc, MUL_LAT + 1);
            end
        end
        total++;
        if (multi_ready != 0) begin bad++; $display("FAIL y_multi_ready got=%0d want=0", multi_ready); end
    endtask

    task automatic test_round_robin();
        reset_dut();
        y_total = 128; cb_total = 64; cr_total = 64;
        wait_outputs(256, 700, "rr");
        total++;
        if (iss_q.size() != 256) begin bad++; $display("FAIL rr_issue_count got=%0d want=256", iss_q.size()); end
        for (int i = 0; i < iss_q.size() && i < 256; i++) begin
            total++;
            if (iss_q[i].a !== rr_exp_a(i) || iss_q[i].tbl !== (rr_exp_comp(i) != 2'd0)
                || iss_q[i].row !== 3'(i % 8) || iss_q[i].col !== 3'((i % 64) / 8)) begin
                bad++;
                $display("FAIL rr_issue[%0d] got a=%h tbl=%b row=%0d col=%0d want a=%h tbl=%b",
                         i, iss_q[i].a, iss_q[i].tbl, iss_q[i].row, iss_q[i].col,
                         rr_exp_a(i), rr_exp_comp(i) != 2'd0);
            end
        end
        for (int b = 1; b < 4; b++) begin
            if (iss_q.size() > 64 * b) begin
                total++;
                if (iss_q[64*b].cyc - iss_q[64*b-1].cyc != 2) begin
                    bad++;
                    $display("FAIL rr_gap[%0d] got=%0d cycles want=2", b, iss_q[64*b].cyc - iss_q[64*b-1].cyc);
                end
            end
        end
        for (int i = 0; i < out_q.size() && i < 256; i++) begin
            total++;
            if (out_q[i].data !== (rr_exp_a(i) ^ SIGN) || out_q[i].comp !== rr_exp_comp(i)
                || out_q[i].last !== (i % 64 == 63)) begin
                bad++;
                $display("FAIL rr_out[%0d] got data=%h comp=%0d last=%b want data=%h comp=%0d",
                         i, out_q[i].data, out_q[i].comp, out_q[i].last, rr_exp_a(i) ^ SIGN, rr_exp_comp(i));
            end
        end
        total++;
        if (multi_ready != 0) begin bad++; $display("FAIL rr_multi_ready got=%0d want=0", multi_ready); end
    endtask

    task automatic test_backpressure();
        int left, popped;
        reset_dut();
        y_total = 64;
        left = 200;
        while (y_sent < 20 && left > 0) begin step(); left--; end
        out_rdy = 1'b0;
        popped = out_q.size();
        repeat (200) step();
        total += 4;
        if (y_sent - out_q.size() != FIFO_DEPTH) begin
            bad++; $display("FAIL bp_held got=%0d want=%0d", y_sent - out_q.size(), FIFO_DEPTH);
        end
        if (out_q.size() != popped) begin bad++; $display("FAIL bp_pops got=%0d want=%0d", out_q.size(), popped); end
        if (s_y_ready !== 1'b0) begin bad++; $display("FAIL bp_y_ready got=%b want=0", s_y_ready); end
        if (s_out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid got=%b want=1", s_out_valid); end
        out_rdy = 1'b1;
        wait_outputs(64, 400, "bp");
        for (int i = 0; i < out_q.size() && i < 64; i++) begin
            total++;
            if (out_q[i].data !== ((Y_BASE + 32'(i)) ^ SIGN) || out_q[i].comp !== 2'd0
                || out_q[i].last !== (i == 63)) begin
                bad++;
                $display("FAIL bp_out[%0d] got data=%h comp=%0d last=%b want data=%h comp=0 last=%b",
                         i, out_q[i].data, out_q[i].comp, out_q[i].last, (Y_BASE + 32'(i)) ^ SIGN, i == 63);
            end
        end
    endtask

    task automatic test_rr_wrap();
        int left;
        reset_dut();
        cr_total = 64;
        left = 200;
        while (cr_sent < 64 && left > 0) begin step(); left--; end
        y_total = 64;
        cb_total = 64;
        wait_outputs(192, 500, "wrap");
        if (iss_q.size() >= 129) begin
            total += 3;
            if (iss_q[0].a !== CR_BASE || iss_q[0].tbl !== 1'b1) begin
                bad++; $display("FAIL wrap_first got a=%h tbl=%b want a=%h tbl=1", iss_q[0].a, iss_q[0].tbl, CR_BASE);
            end
            if (iss_q[64].a !== Y_BASE || iss_q[64].tbl !== 1'b0) begin
                bad++; $display("FAIL wrap_second got a=%h tbl=%b want a=%h tbl=0", iss_q[64].a, iss_q[64].tbl, Y_BASE);
            end
            if (iss_q[128].a !== CB_BASE || iss_q[128].tbl !== 1'b1) begin
                bad++; $display("FAIL wrap_third got a=%h tbl=%b want a=%h tbl=1", iss_q[128].a, iss_q[128].tbl, CB_BASE);
            end
        end
        if (out_q.size() >= 65) begin
            total += 2;
            if (out_q[63].comp !== 2'd2 || out_q[63].last !== 1'b1) begin
                bad++; $display("FAIL wrap_out63 got comp=%0d last=%b want comp=2 last=1", out_q[63].comp, out_q[63].last);
            end
            if (out_q[64].comp !== 2'd0 || out_q[64].data !== (Y_BASE ^ SIGN)) begin
                bad++; $display("FAIL wrap_out64 got comp=%0d data=%h want comp=0 data=%h",
                                out_q[64].comp, out_q[64].data, Y_BASE ^ SIGN);
            end
        end
    endtask

    task automatic test_reset_mid_block();
        int left;
        reset_dut();
        cb_total = 64;
        left = 200;
        while (cb_sent < 30 && left > 0) begin step(); left--; end
        total += 2;
        if (cb_sent != 30) begin bad++; $display("FAIL mid_cb_sent got=%0d want=30", cb_sent); end
        if (s_out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_out_valid got=%b want=1", s_out_valid); end
        rst_drive = 1'b1;
        step();
        total += 3;
        if ({s_y_ready, s_cb_ready, s_cr_ready} !== 3'b000) begin
            bad++; $display("FAIL mid_rst_readys got=%b want=000", {s_y_ready, s_cb_ready, s_cr_ready});
        end
        if (s_out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid got=%b want=0", s_out_valid); end
        if (s_mul_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_mul_valid got=%b want=0", s_mul_valid); end
        rst_drive = 1'b0;
        clear_streams();
        y_total = 64;
        cr_total = 64;
        wait_outputs(128, 500, "mid");
        repeat (20) step();
        total += 2;
        if (out_q.size() != 128) begin bad++; $display("FAIL mid_out_count got=%0d want=128", out_q.size()); end
        if (iss_q.size() != 128) begin bad++; $display("FAIL mid_issue_count got=%0d want=128", iss_q.size()); end
        if (iss_q.size() > 0) begin
            total++;
            if (iss_q[0].a !== Y_BASE || iss_q[0].tbl !== 1'b0 || iss_q[0].row !== 3'd0 || iss_q[0].col !== 3'd0) begin
                bad++;
                $display("FAIL mid_first_issue got a=%h tbl=%b row=%0d col=%0d want a=%h tbl=0 row=0 col=0",
                         iss_q[0].a, iss_q[0].tbl, iss_q[0].row, iss_q[0].col, Y_BASE);
            end
        end
        if (out_q.size() > 64) begin
            total += 2;
            if (out_q[0].data !== (Y_BASE ^ SIGN) || out_q[0].comp !== 2'd0) begin
                bad++; $display("FAIL mid_first_out got data=%h comp=%0d want data=%h comp=0",
                                out_q[0].data, out_q[0].comp, Y_BASE ^ SIGN);
            end
            if (out_q[64].data !== (CR_BASE ^ SIGN) || out_q[64].comp !== 2'd2) begin
                bad++; $display("FAIL mid_cr_out got data=%h comp=%0d want data=%h comp=2",
                                out_q[64].data, out_q[64].comp, CR_BASE ^ SIGN);
            end
        end
    endtask

`ifdef QUANT_STATS_EN
    task automatic test_stats();
        reset_dut();
        y_total = 192;
        cr_total = 64;
        wait_outputs(256, 700, "stats");
        repeat (5) step();
        total += 3;
        if (stat_blk_y !== 16'd3)  begin bad++; $display("FAIL stat_blk_y got=%0d want=3", stat_blk_y); end
        if (stat_blk_cb !== 16'd0) begin bad++; $display("FAIL stat_blk_cb got=%0d want=0", stat_blk_cb); end
        if (stat_blk_cr !== 16'd1) begin bad++; $display("FAIL stat_blk_cr got=%0d want=1", stat_blk_cr); end
    endtask
`endif

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1; rst_drive = 1'b1; out_rdy = 1'b1;
        y_valid = 1'b0; cb_valid = 1'b0; cr_valid = 1'b0;
        y_data = '0; cb_data = '0; cr_data = '0;
        mul_res_valid = 1'b0; mul_res = '0; out_ready = 1'b1;
        last_v = 1'b0; last_a = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = '0;
        end
        clear_streams();
        test_reset();
        test_y_block();
        test_round_robin();
        test_backpressure();
        test_rr_wrap();
        test_reset_mid_block();
`ifdef QUANT_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
